// File: rtl/ghost_mover.sv
// Single-ghost movement engine: tick divider, chase/scatter/respawn mode FSM,
// greedy direction choice toward the current target and a saturating position step.
module ghost_mover #(
  parameter int START_X       = 320,
  parameter int START_Y       = 240,
  parameter int STEP          = 2,
  parameter int TICK_DIV      = 400000,
  parameter int CORNER_X      = 16,
  parameter int CORNER_Y      = 16,
  parameter int CHASE_TICKS   = 1000,
  parameter int SCATTER_TICKS = 300,
  parameter int RESPAWN_TICKS = 150,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 639,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 479
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       restart,
  input  logic [9:0] PacX,
  input  logic [8:0] PacY,
  input  logic [3:0] blocked,
  output logic [9:0] GhostX,
  output logic [8:0] GhostY,
  output logic [1:0] dir,
  output logic [1:0] mode,
  output logic       moved
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHASE   = 2'd1;
  localparam logic [1:0] SCATTER = 2'd2;
  localparam logic [1:0] RESPAWN = 2'd3;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int T_MAX = (CHASE_TICKS > SCATTER_TICKS)
                         ? ((CHASE_TICKS > RESPAWN_TICKS) ? CHASE_TICKS : RESPAWN_TICKS)
                         : ((SCATTER_TICKS > RESPAWN_TICKS) ? SCATTER_TICKS : RESPAWN_TICKS);
  localparam int TMR_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] CHASE_LAST   = TMR_W'(CHASE_TICKS - 1);
  localparam logic [TMR_W-1:0] SCATTER_LAST = TMR_W'(SCATTER_TICKS - 1);
  localparam logic [TMR_W-1:0] RESPAWN_LAST = TMR_W'(RESPAWN_TICKS - 1);

  localparam logic signed [11:0] STEP_X = 12'(STEP);
  localparam logic signed [10:0] STEP_Y = 11'(STEP);
  localparam logic signed [11:0] X_LO   = 12'(X_MIN);
  localparam logic signed [11:0] X_HI   = 12'(X_MAX);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [1:0]       mode_reg, mode_next;
  logic [1:0]       dir_reg, dir_next;
  logic [9:0]       x_reg, x_next;
  logic [8:0]       y_reg, y_next;
  logic             moved_reg, moved_next;
  logic             tick;

  logic [9:0]         tgt_x;
  logic [8:0]         tgt_y;
  logic signed [10:0] dx;
  logic signed [9:0]  dy;
  logic [10:0]        adx;
  logic [9:0]         ady;
  logic [1:0]         prim, sec, rev, pick;
  logic               sec_ok, has_tgt, found;
  logic [1:0]         cand [7];
  logic [6:0]         cand_ok;

  logic signed [11:0] step_x;
  logic signed [10:0] step_y;
  logic [9:0]         x_sat;
  logic [8:0]         y_sat;

  assign tick = en && (cnt_reg == CNT_LAST);

  always_comb begin
    tgt_x = (mode_reg == SCATTER) ? 10'(CORNER_X) : PacX;
    tgt_y = (mode_reg == SCATTER) ? 9'(CORNER_Y) : PacY;
    dx    = $signed({1'b0, tgt_x}) - $signed({1'b0, x_reg});
    dy    = $signed({1'b0, tgt_y}) - $signed({1'b0, y_reg});
    adx   = dx[10] ? -dx : dx;
    ady   = dy[9] ? -dy : dy;
    has_tgt = (dx != 0) || (dy != 0);
    // Ties on |dx| == |dy| resolve to the X axis.
    if (adx >= {1'b0, ady}) begin
      prim   = dx[10] ? LEFT : RIGHT;
      sec    = dy[9] ? UP : DOWN;
      sec_ok = (dy != 0);
    end else begin
      prim   = dy[9] ? UP : DOWN;
      sec    = dx[10] ? LEFT : RIGHT;
      sec_ok = (dx != 0);
    end
    rev     = {dir_reg[1], ~dir_reg[0]};
    cand[0] = prim;
    cand[1] = sec;
    cand[2] = dir_reg;
    for (int i = 0; i < 4; i++) cand[i+3] = 2'(i);
    cand_ok = {4'b1111, 1'b1, sec_ok, 1'b1} & {7{has_tgt}};
    found   = 1'b0;
    pick    = rev;
    // Scan from lowest priority up so the highest-priority open candidate wins.
    for (int i = 6; i >= 0; i--) begin
      if (cand_ok[i] && !blocked[cand[i]] && (cand[i] != rev)) begin
        found = 1'b1;
        pick  = cand[i];
      end
    end
    if (!found && has_tgt && !blocked[rev]) found = 1'b1;
  end

  always_comb begin
    step_x = $signed({2'b00, x_reg});
    step_y = $signed({2'b00, y_reg});
    case (pick)
      UP:      step_y = step_y - STEP_Y;
      DOWN:    step_y = step_y + STEP_Y;
      LEFT:    step_x = step_x - STEP_X;
      default: step_x = step_x + STEP_X;
    endcase
    if (step_x < X_LO)      x_sat = 10'(X_MIN);
    else if (step_x > X_HI) x_sat = 10'(X_MAX);
    else                    x_sat = step_x[9:0];
    if (step_y < Y_LO)      y_sat = 9'(Y_MIN);
    else if (step_y > Y_HI) y_sat = 9'(Y_MAX);
    else                    y_sat = step_y[8:0];
  end

  always_comb begin
    cnt_next   = cnt_reg;
    timer_next = timer_reg;
    mode_next  = mode_reg;
    dir_next   = dir_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    moved_next = 1'b0;
    if (en) cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
    // Restart wins over a coincident tick and is honoured even while frozen.
    if (restart && (mode_reg != IDLE)) begin
      x_next     = 10'(START_X);
      y_next     = 9'(START_Y);
      dir_next   = UP;
      mode_next  = RESPAWN;
      timer_next = '0;
    end else if (en) begin
      if (mode_reg == IDLE) begin
        mode_next  = CHASE;
        timer_next = '0;
      end else if (tick) begin
        if ((mode_reg != RESPAWN) && found) begin
          dir_next   = pick;
          x_next     = x_sat;
          y_next     = y_sat;
          moved_next = (x_sat != x_reg) || (y_sat != y_reg);
        end
        timer_next = timer_reg + TMR_W'(1);
        case (mode_reg)
          CHASE:   if (timer_reg == CHASE_LAST)   begin mode_next = SCATTER; timer_next = '0; end
          SCATTER: if (timer_reg == SCATTER_LAST) begin mode_next = CHASE;   timer_next = '0; end
          default: if (timer_reg == RESPAWN_LAST) begin mode_next = CHASE;   timer_next = '0; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      timer_reg <= '0;
      mode_reg  <= IDLE;
      dir_reg   <= UP;
      x_reg     <= 10'(START_X);
      y_reg     <= 9'(START_Y);
      moved_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      timer_reg <= timer_next;
      mode_reg  <= mode_next;
      dir_reg   <= dir_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      moved_reg <= moved_next;
    end
  end

  assign GhostX = x_reg;
  assign GhostY = y_reg;
  assign dir    = dir_reg;
  assign mode   = mode_reg;
  assign moved  = moved_reg;

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: table of one-tick vectors, directed multi-cycle corner
// cases, then randomized stimulus against a per-cycle behavioural model.
module tb_ghost_mover;
  localparam int TICK_DIV = 4;
  localparam int STEP     = 2;

  logic       clk, rst, en, restart;
  logic [9:0] PacX;
  logic [8:0] PacY;
  logic [3:0] blocked;
  logic [9:0] GhostX;
  logic [8:0] GhostY;
  logic [1:0] dir, mode;
  logic       moved;

  ghost_mover #(
    .TICK_DIV(TICK_DIV), .STEP(STEP), .CHASE_TICKS(5), .SCATTER_TICKS(3), .RESPAWN_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .PacX(PacX), .PacY(PacY),
    .blocked(blocked), .GhostX(GhostX), .GhostY(GhostY), .dir(dir), .mode(mode), .moved(moved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         rs;
    int         px, py;
    logic [3:0] blk;
    int         ex, ey, ed, em, emv;
  } vec_t;

  int   n_vec, n_bad;
  vec_t tbl [26];

  // Behavioural model state (value after the most recent clock edge)
  int m_x, m_y, m_dir, m_mode, m_moved, m_cnt, m_timer;

  function automatic vec_t mk(bit rs, int px, int py, logic [3:0] blk,
                              int ex, int ey, int ed, int em, int emv);
    vec_t v;
    v.rs = rs; v.px = px; v.py = py; v.blk = blk;
    v.ex = ex; v.ey = ey; v.ed = ed; v.em = em; v.emv = emv;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic window(input int n, output int mv);
    mv = 0;
    repeat (n) begin
      @(negedge clk);
      if (moved) mv++;
    end
  endtask

  // Restart pulse plus enough cycles for the two respawn ticks to elapse.
  task automatic do_restart(output int mv);
    int m2;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    mv = moved ? 1 : 0;
    window(8, m2);
    mv += m2;
  endtask

  // 0 up, 1 down, 2 left, 3 right; -1 when no move is possible.
  function automatic int pick_dir(int gx, int gy, int cur, int tx, int ty, logic [3:0] blk);
    int dx, dy, rev;
    int order[$];
    dx = tx - gx;
    dy = ty - gy;
    if (dx == 0 && dy == 0) return -1;
    rev = (cur == 0) ? 1 : (cur == 1) ? 0 : (cur == 2) ? 3 : 2;
    if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) begin
      order.push_back(dx > 0 ? 3 : 2);
      if (dy != 0) order.push_back(dy > 0 ? 1 : 0);
    end else begin
      order.push_back(dy > 0 ? 1 : 0);
      if (dx != 0) order.push_back(dx > 0 ? 3 : 2);
    end
    order.push_back(cur);
    for (int d = 0; d < 4; d++) order.push_back(d);
    foreach (order[i]) if (!blk[order[i]] && order[i] != rev) return order[i];
    if (!blk[rev]) return rev;
    return -1;
  endfunction

  task automatic model_step();
    int  c, tx, ty, nx, ny, limit;
    bit  tk;
    tk = en && (m_cnt == TICK_DIV - 1);
    m_moved = 0;
    if (restart && m_mode != 0) begin
      m_x = 320; m_y = 240; m_dir = 0; m_mode = 3; m_timer = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (tk) begin
        m_timer++;
        if (m_mode != 3) begin
          tx = (m_mode == 1) ? int'(PacX) : 16;
          ty = (m_mode == 1) ? int'(PacY) : 16;
          c  = pick_dir(m_x, m_y, m_dir, tx, ty, blocked);
          if (c >= 0) begin
            nx = m_x + ((c == 3) ? STEP : (c == 2) ? -STEP : 0);
            ny = m_y + ((c == 1) ? STEP : (c == 0) ? -STEP : 0);
            nx = (nx < 0) ? 0 : (nx > 639) ? 639 : nx;
            ny = (ny < 0) ? 0 : (ny > 479) ? 479 : ny;
            m_moved = (nx != m_x || ny != m_y) ? 1 : 0;
            m_x = nx; m_y = ny; m_dir = c;
          end
        end
        limit = (m_mode == 1) ? 5 : (m_mode == 2) ? 3 : 2;
        if (m_timer == limit) begin
          m_timer = 0;
          m_mode  = (m_mode == 1) ? 2 : 1;
        end
      end
    end
    if (en) m_cnt = (m_cnt + 1) % TICK_DIV;
  endtask

  initial begin
    vec_t v;
    int   mv, found, act, exp;

    n_vec = 0; n_bad = 0;
    rst = 1'b0; en = 1'b0; restart = 1'b0;
    PacX = 10'd400; PacY = 9'd240; blocked = 4'b0000;

    tbl[0]  = mk(1,   0,   0, 4'b0000, 320, 240, 0, 1, 0);
    tbl[1]  = mk(0, 300, 240, 4'b0000, 318, 240, 2, 1, 1);
    tbl[2]  = mk(0, 330, 240, 4'b0111, 320, 240, 3, 1, 1);
    tbl[3]  = mk(0, 330, 100, 4'b0000, 320, 238, 0, 1, 1);
    tbl[4]  = mk(1,   0,   0, 4'b0000, 320, 240, 0, 1, 0);
    tbl[5]  = mk(0, 300, 240, 4'b0000, 318, 240, 2, 1, 1);
    tbl[6]  = mk(0, 330, 240, 4'b0111, 320, 240, 3, 1, 1);
    tbl[7]  = mk(0, 330, 100, 4'b0001, 322, 240, 3, 1, 1);
    tbl[8]  = mk(1,   0,   0, 4'b0000, 320, 240, 0, 1, 0);
    tbl[9]  = mk(0, 300, 240, 4'b0000, 318, 240, 2, 1, 1);
    tbl[10] = mk(0, 330, 240, 4'b0111, 320, 240, 3, 1, 1);
    tbl[11] = mk(0, 330, 100, 4'b1011, 318, 240, 2, 1, 1);
    tbl[12] = mk(1,   0,   0, 4'b0000, 320, 240, 0, 1, 0);
    tbl[13] = mk(0, 320, 240, 4'b0000, 320, 240, 0, 1, 0);
    tbl[14] = mk(0, 400, 240, 4'b1111, 320, 240, 0, 1, 0);
    tbl[15] = mk(0, 330, 250, 4'b0000, 322, 240, 3, 1, 1);
    tbl[16] = mk(1,   0,   0, 4'b0000, 320, 240, 0, 1, 0);
    tbl[17] = mk(0, 600, 240, 4'b0000, 322, 240, 3, 1, 1);
    tbl[18] = mk(0, 600, 240, 4'b0000, 324, 240, 3, 1, 1);
    tbl[19] = mk(0, 600, 240, 4'b0000, 326, 240, 3, 1, 1);
    tbl[20] = mk(0, 600, 240, 4'b0000, 328, 240, 3, 1, 1);
    tbl[21] = mk(0, 600, 240, 4'b0000, 330, 240, 3, 2, 1);
    tbl[22] = mk(0, 600, 240, 4'b0000, 330, 238, 0, 2, 1);
    tbl[23] = mk(0, 600, 240, 4'b0000, 328, 238, 2, 2, 1);
    tbl[24] = mk(0, 600, 240, 4'b0000, 326, 238, 2, 1, 1);
    tbl[25] = mk(0, 600, 240, 4'b0000, 326, 240, 1, 1, 1);

    // Reset values, then release with en=1
    repeat (2) @(negedge clk);
    check("rst.x", GhostX, 320);
    check("rst.y", GhostY, 240);
    check("rst.mode", mode, 0);
    check("rst.dir", dir, 0);
    check("rst.moved", moved, 0);
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    check("en.mode", mode, 1);
    window(2, mv);
    check("en.early_moves", mv, 0);
    @(negedge clk);
    check("en.moved", moved, 1);
    check("en.x", GhostX, 322);
    @(negedge clk);
    check("en.pulse_width", moved, 0);

    // One tick per vector; restart rows reset position and wait out respawn
    for (int i = 0; i < 26; i++) begin
      v = tbl[i];
      PacX = 10'(v.px); PacY = 9'(v.py); blocked = v.blk;
      if (v.rs) do_restart(mv);
      else      window(TICK_DIV, mv);
      check($sformatf("v%0d.x", i), GhostX, v.ex);
      check($sformatf("v%0d.y", i), GhostY, v.ey);
      check($sformatf("v%0d.dir", i), dir, v.ed);
      check($sformatf("v%0d.mode", i), mode, v.em);
      check($sformatf("v%0d.moves", i), mv, v.emv);
    end

    // Restart landing exactly on a tick cycle
    PacX = 10'd600; PacY = 9'd240; blocked = 4'b0000;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      @(negedge clk);
      if (moved) found = 1;
    end
    check("coll.sync", found, 1);
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("coll.x", GhostX, 320);
    check("coll.y", GhostY, 240);
    check("coll.mode", mode, 3);
    check("coll.moved", moved, 0);
    window(7, mv);
    check("coll.hold_mode", mode, 3);
    window(1, act);
    mv += act;
    check("coll.chase", mode, 1);
    check("coll.hold_x", GhostX, 320);
    check("coll.hold_moves", mv, 0);

    // Drive into the right-hand wall and sit there
    PacX = 10'd639; PacY = 9'd240; blocked = 4'b0111;
    do_restart(mv);
    window(159 * TICK_DIV, mv);
    check("sat.x638", GhostX, 638);
    check("sat.moves159", mv, 159);
    window(TICK_DIV, mv);
    check("sat.x639", GhostX, 639);
    check("sat.clamp_move", mv, 1);
    window(10 * TICK_DIV, mv);
    check("sat.idle_moves", mv, 0);
    check("sat.x_hold", GhostX, 639);
    check("sat.y_hold", GhostY, 240);
    check("sat.dir", dir, 3);

    // Freeze mid-count
    PacX = 10'd600; PacY = 9'd240; blocked = 4'b0000;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    found = 0;
    for (int k = 0; k < 16 && found == 0; k++) begin
      @(negedge clk);
      if (moved) found = 1;
    end
    check("frz.sync", found, 1);
    @(negedge clk);
    en = 1'b0;
    window(10, mv);
    check("frz.moves", mv, 0);
    check("frz.x", GhostX, 322);
    check("frz.y", GhostY, 240);
    check("frz.dir", dir, 3);
    check("frz.mode", mode, 1);
    en = 1'b1;
    window(2, mv);
    check("frz.resume_early", mv, 0);
    @(negedge clk);
    check("frz.resume_moved", moved, 1);
    check("frz.resume_x", GhostX, 324);
    en = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("frz.restart_mode", mode, 3);
    check("frz.restart_x", GhostX, 320);
    en = 1'b1;

    // Asynchronous reset acts before the next clock edge
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async.mode", mode, 0);
    check("async.x", GhostX, 320);
    check("async.dir", dir, 0);

    // Randomized run against the behavioural model
    m_x = 320; m_y = 240; m_dir = 0; m_mode = 0; m_moved = 0; m_cnt = 0; m_timer = 0;
    @(negedge clk);
    for (int k = 0; k < 3000; k++) begin
      act = int'({GhostX, GhostY, dir, mode, moved});
      exp = (m_x << 14) | (m_y << 5) | (m_dir << 3) | (m_mode << 1) | m_moved;
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL rand[%0d]: got x=%0d y=%0d dir=%0d mode=%0d moved=%0d, expected x=%0d y=%0d dir=%0d mode=%0d moved=%0d",
                 k, GhostX, GhostY, dir, mode, moved, m_x, m_y, m_dir, m_mode, m_moved);
      end
      rst     = 1'b1;
      PacX    = 10'($urandom_range(0, 1023));
      PacY    = 9'($urandom_range(0, 511));
      blocked = 4'($urandom & $urandom);
      en      = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 99) == 0);
      model_step();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
